// File: rtl/audio_irq_ctrl.sv
// Interrupt controller: synchronises, latches, masks and prioritises up to 16
// sources into one registered irq plus index, behind a 16-bit Avalon-MM slave.
module audio_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic [NUM_SRC-1:0] sync1_r;
    logic [NUM_SRC-1:0] sync2_r;
    logic [15:0]        prev_r;
    logic [15:0]        pending_r;
    logic [15:0]        enable_r;
    logic [15:0]        mode_r;

    logic [15:0] raw_s;
    logic [15:0] set_s;
    logic [15:0] w1c_s;
    logic [15:0] ack_s;
    logic [15:0] force_s;
    logic [15:0] active_s;
    logic [15:0] pending_nxt_s;
    logic [15:0] read_mux_s;
    logic [3:0]  index_s;
    logic        valid_s;
    logic        wr_s;

    function automatic logic [15:0] widen(input logic [NUM_SRC-1:0] v);
        logic [15:0] w;
        w = 16'd0;
        w[NUM_SRC-1:0] = v;
        return w;
    endfunction

    // Bit 0 has the highest priority; returns 0 when nothing is set.
    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign raw_s    = widen(sync2_r);
    assign active_s = pending_r & enable_r;
    assign valid_s  = |active_s;
    assign index_s  = lowest_index(active_s);
    assign wr_s     = chipselect & ~write_n;
    assign set_s    = (mode_r & raw_s & ~prev_r) | (~mode_r & raw_s);
    // Set takes priority over clear so a still-asserted level source re-pends.
    assign pending_nxt_s = ((pending_r & ~(w1c_s | ack_s)) | set_s | force_s) & SRC_MASK;

    // Register-write decode and read-data selection.
    always_comb begin
        w1c_s      = 16'd0;
        ack_s      = 16'd0;
        force_s    = 16'd0;
        read_mux_s = 16'd0;
        if (wr_s) begin
            case (address)
                3'd0: w1c_s = writedata;
                3'd3: begin
                    if (valid_s) begin
                        ack_s = 16'd1 << index_s;
                    end else begin
                        ack_s = 16'd0;
                    end
                end
                3'd4: force_s = writedata;
                default: w1c_s = 16'd0;
            endcase
        end else begin
            w1c_s = 16'd0;
        end
        case (address)
            3'd0:    read_mux_s = pending_r;
            3'd1:    read_mux_s = enable_r;
            3'd2:    read_mux_s = mode_r;
            3'd3:    read_mux_s = {valid_s, 11'd0, index_s};
            3'd5:    read_mux_s = raw_s;
            default: read_mux_s = 16'd0;
        endcase
    end

    // Synchronisers, interrupt state, configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= {NUM_SRC{1'b0}};
            sync2_r   <= {NUM_SRC{1'b0}};
            prev_r    <= 16'd0;
            pending_r <= 16'd0;
            enable_r  <= 16'd0;
            mode_r    <= 16'd0;
            readdata  <= 16'd0;
            irq       <= 1'b0;
            irq_id    <= 4'd0;
        end else begin
            sync1_r   <= irq_in;
            sync2_r   <= sync1_r;
            prev_r    <= raw_s;
            pending_r <= pending_nxt_s;
            readdata  <= read_mux_s;
            irq       <= valid_s;
            irq_id    <= index_s;
            if (wr_s && (address == 3'd1)) begin
                enable_r <= writedata & SRC_MASK;
            end
            if (wr_s && (address == 3'd2)) begin
                mode_r <= writedata & SRC_MASK;
            end
        end
    end

endmodule
